// File: rtl/e_stage_mdu_pkg.sv
// Shared opcode encodings, forwarding selects and small helpers for the execute stage.
package e_stage_mdu_pkg;

  localparam logic [2:0] ALU_ADD  = 3'd0;
  localparam logic [2:0] ALU_SUB  = 3'd1;
  localparam logic [2:0] ALU_OR   = 3'd2;
  localparam logic [2:0] ALU_AND  = 3'd3;
  localparam logic [2:0] ALU_LUI  = 3'd4;
  localparam logic [2:0] ALU_SLT  = 3'd5;
  localparam logic [2:0] ALU_SLTU = 3'd6;
  localparam logic [2:0] ALU_XOR  = 3'd7;

  localparam logic [2:0] MD_MULT  = 3'd1;
  localparam logic [2:0] MD_MULTU = 3'd2;
  localparam logic [2:0] MD_DIV   = 3'd3;
  localparam logic [2:0] MD_DIVU  = 3'd4;
  localparam logic [2:0] MD_MTHI  = 3'd5;
  localparam logic [2:0] MD_MTLO  = 3'd6;

  localparam logic [1:0] MDREAD_HI = 2'd1;
  localparam logic [1:0] MDREAD_LO = 2'd2;

  localparam logic [1:0] FWD_REG = 2'd0;
  localparam logic [1:0] FWD_M   = 2'd1;
  localparam logic [1:0] FWD_W   = 2'd2;

  // Width-independent control fields of the D/E pipeline register.
  typedef struct packed {
    logic [4:0] rs;
    logic [4:0] rt;
    logic [4:0] reg_addr;
    logic       reg_write;
    logic [2:0] alu_op;
    logic       alu_src;
    logic [2:0] md_op;
    logic [1:0] md_read;
    logic [2:0] tnew;
  } ctrl_t;

  function automatic logic [1:0] fwd_sel(input logic [4:0] addr,
                                         input logic       m_we,
                                         input logic [4:0] m_addr,
                                         input logic       w_we,
                                         input logic [4:0] w_addr);
    if (addr != 5'd0 && m_we && m_addr == addr) return FWD_M;
    if (addr != 5'd0 && w_we && w_addr == addr) return FWD_W;
    return FWD_REG;
  endfunction

  function automatic logic [2:0] tnew_dec(input logic [2:0] t);
    return (t == 3'd0) ? 3'd0 : t - 3'd1;
  endfunction

endpackage

// File: rtl/e_stage_mdu_if.sv
// D-stage inputs, M/W forwarding sources and E-stage outputs of the execute stage.
interface e_stage_mdu_if #(
  parameter int WIDTH = 32
);
  logic             Stall;
  logic [WIDTH-1:0] D_Instr, D_PC, D_PC8, D_RD1, D_RD2, D_Imm;
  logic [4:0]       D_rs, D_rt, D_RegAddr;
  logic             D_RegWrite;
  logic [2:0]       D_ALUop;
  logic             D_ALUSrc;
  logic [2:0]       D_MDop;
  logic [1:0]       D_MDRead;
  logic             D_UsesMD;
  logic [2:0]       D_Tnew;

  logic [WIDTH-1:0] M_RegData, W_RegData;
  logic [4:0]       M_RegAddr, W_RegAddr;
  logic             M_RegWrite, W_RegWrite;

  logic [WIDTH-1:0] E_Instr, E_PC, E_PC8, E_Result, E_RD2;
  logic [4:0]       E_RegAddr;
  logic             E_RegWrite;
  logic [2:0]       E_Tnew;
  logic             E_MDBusy, E_MDStall;

  modport master (
    output Stall, D_Instr, D_PC, D_PC8, D_RD1, D_RD2, D_Imm, D_rs, D_rt, D_RegAddr,
           D_RegWrite, D_ALUop, D_ALUSrc, D_MDop, D_MDRead, D_UsesMD, D_Tnew,
           M_RegData, W_RegData, M_RegAddr, W_RegAddr, M_RegWrite, W_RegWrite,
    input  E_Instr, E_PC, E_PC8, E_Result, E_RD2, E_RegAddr, E_RegWrite, E_Tnew,
           E_MDBusy, E_MDStall
  );

  modport slave (
    input  Stall, D_Instr, D_PC, D_PC8, D_RD1, D_RD2, D_Imm, D_rs, D_rt, D_RegAddr,
           D_RegWrite, D_ALUop, D_ALUSrc, D_MDop, D_MDRead, D_UsesMD, D_Tnew,
           M_RegData, W_RegData, M_RegAddr, W_RegAddr, M_RegWrite, W_RegWrite,
    output E_Instr, E_PC, E_PC8, E_Result, E_RD2, E_RegAddr, E_RegWrite, E_Tnew,
           E_MDBusy, E_MDStall
  );
endinterface

// File: rtl/e_stage_mdu_mdu.sv
// Multi-cycle multiply/divide unit: latches operands on start, counts down, commits HI/LO on the last busy cycle.
// Busy is high for exactly MULT_CYCLES/DIV_CYCLES cycles; no backpressure, the pipeline stalls around it.
module e_mdu
  import e_stage_mdu_pkg::*;
#(
  parameter int WIDTH       = 32,
  parameter int MULT_CYCLES = 5,
  parameter int DIV_CYCLES  = 10
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [2:0]       op_i,
  input  logic [WIDTH-1:0] a_i,
  input  logic [WIDTH-1:0] b_i,
  output logic             start_o,
  output logic             busy_o,
  output logic [WIDTH-1:0] hi_o,
  output logic [WIDTH-1:0] lo_o
);

  localparam int MAXC = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
  localparam int CW   = $clog2(MAXC + 1);

  logic [CW-1:0]      cnt_q, cnt_d;
  logic [2:0]         op_q;
  logic [WIDTH-1:0]   a_q, b_q, hi_q, hi_d, lo_q, lo_d;
  logic [2*WIDTH-1:0] prod_s, prod_u;
  logic [WIDTH-1:0]   b_safe, quot_s, rem_s, quot_u, rem_u;
  logic               b_nz;

  assign busy_o  = (cnt_q != '0);
  assign start_o = (op_i >= MD_MULT) && (op_i <= MD_DIVU) && !busy_o;
  assign hi_o    = hi_q;
  assign lo_o    = lo_q;

  assign prod_s = {{WIDTH{a_q[WIDTH-1]}}, a_q} * {{WIDTH{b_q[WIDTH-1]}}, b_q};
  assign prod_u = {{WIDTH{1'b0}}, a_q} * {{WIDTH{1'b0}}, b_q};
  // A zero divisor never commits, so the substituted 1 only keeps the divider well defined.
  assign b_nz   = (b_q != '0);
  assign b_safe = b_nz ? b_q : {{(WIDTH-1){1'b0}}, 1'b1};
  assign quot_s = $signed(a_q) / $signed(b_safe);
  assign rem_s  = $signed(a_q) % $signed(b_safe);
  assign quot_u = a_q / b_safe;
  assign rem_u  = a_q % b_safe;

  always_comb begin
    cnt_d = cnt_q;
    hi_d  = hi_q;
    lo_d  = lo_q;
    if (start_o) begin
      cnt_d = (op_i == MD_MULT || op_i == MD_MULTU) ? CW'(MULT_CYCLES) : CW'(DIV_CYCLES);
    end else if (busy_o) begin
      cnt_d = cnt_q - CW'(1);
    end
    if (busy_o && cnt_q == CW'(1)) begin
      case (op_q)
        MD_MULT:  begin hi_d = prod_s[2*WIDTH-1:WIDTH]; lo_d = prod_s[WIDTH-1:0]; end
        MD_MULTU: begin hi_d = prod_u[2*WIDTH-1:WIDTH]; lo_d = prod_u[WIDTH-1:0]; end
        MD_DIV:   if (b_nz) begin hi_d = rem_s; lo_d = quot_s; end
        MD_DIVU:  if (b_nz) begin hi_d = rem_u; lo_d = quot_u; end
        default: ;
      endcase
    end else if (!busy_o && op_i == MD_MTHI) begin
      hi_d = a_i;
    end else if (!busy_o && op_i == MD_MTLO) begin
      lo_d = a_i;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_q <= '0;
      op_q  <= '0;
      a_q   <= '0;
      b_q   <= '0;
      hi_q  <= '0;
      lo_q  <= '0;
    end else begin
      cnt_q <= cnt_d;
      hi_q  <= hi_d;
      lo_q  <= lo_d;
      if (start_o) begin
        op_q <= op_i;
        a_q  <= a_i;
        b_q  <= b_i;
      end
    end
  end

endmodule

// File: rtl/e_stage_mdu.sv
// Execute stage: D/E register, M/W operand forwarding, single-cycle ALU and HI/LO readout from the MDU.
// One-cycle latency D->E; Stall loads a bubble, E_MDStall asks D to hold MD consumers while the MDU is active.
module e_stage_mdu
  import e_stage_mdu_pkg::*;
#(
  parameter int WIDTH       = 32,
  parameter int MULT_CYCLES = 5,
  parameter int DIV_CYCLES  = 10
) (
  input logic          clk,
  input logic          reset,
  e_stage_mdu_if.slave io
);

  logic [WIDTH-1:0] instr_q, instr_d, pc_q, pc_d, pc8_q, pc8_d;
  logic [WIDTH-1:0] rd1_q, rd1_d, rd2_q, rd2_d, imm_q, imm_d;
  ctrl_t            ctrl_q, ctrl_d;

  logic [1:0]       sel_a, sel_b;
  logic [WIDTH-1:0] fwd_a, fwd_b, alu_b, alu_res, hi, lo;
  logic             md_start, md_busy;

  always_comb begin
    instr_d = '0;
    pc_d    = '0;
    pc8_d   = '0;
    rd1_d   = '0;
    rd2_d   = '0;
    imm_d   = '0;
    ctrl_d  = '0;
    if (!io.Stall) begin
      instr_d          = io.D_Instr;
      pc_d             = io.D_PC;
      pc8_d            = io.D_PC8;
      rd1_d            = io.D_RD1;
      rd2_d            = io.D_RD2;
      imm_d            = io.D_Imm;
      ctrl_d.rs        = io.D_rs;
      ctrl_d.rt        = io.D_rt;
      ctrl_d.reg_addr  = io.D_RegAddr;
      ctrl_d.reg_write = io.D_RegWrite;
      ctrl_d.alu_op    = io.D_ALUop;
      ctrl_d.alu_src   = io.D_ALUSrc;
      ctrl_d.md_op     = io.D_MDop;
      ctrl_d.md_read   = io.D_MDRead;
      ctrl_d.tnew      = io.D_Tnew;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      instr_q <= '0;
      pc_q    <= '0;
      pc8_q   <= '0;
      rd1_q   <= '0;
      rd2_q   <= '0;
      imm_q   <= '0;
      ctrl_q  <= '0;
    end else begin
      instr_q <= instr_d;
      pc_q    <= pc_d;
      pc8_q   <= pc8_d;
      rd1_q   <= rd1_d;
      rd2_q   <= rd2_d;
      imm_q   <= imm_d;
      ctrl_q  <= ctrl_d;
    end
  end

  // M is the younger producer, so it wins over W when both target the same register.
  assign sel_a = fwd_sel(ctrl_q.rs, io.M_RegWrite, io.M_RegAddr, io.W_RegWrite, io.W_RegAddr);
  assign sel_b = fwd_sel(ctrl_q.rt, io.M_RegWrite, io.M_RegAddr, io.W_RegWrite, io.W_RegAddr);

  always_comb begin
    case (sel_a)
      FWD_M:   fwd_a = io.M_RegData;
      FWD_W:   fwd_a = io.W_RegData;
      default: fwd_a = rd1_q;
    endcase
    case (sel_b)
      FWD_M:   fwd_b = io.M_RegData;
      FWD_W:   fwd_b = io.W_RegData;
      default: fwd_b = rd2_q;
    endcase
  end

  assign alu_b = ctrl_q.alu_src ? imm_q : fwd_b;

  always_comb begin
    case (ctrl_q.alu_op)
      ALU_ADD:  alu_res = fwd_a + alu_b;
      ALU_SUB:  alu_res = fwd_a - alu_b;
      ALU_OR:   alu_res = fwd_a | alu_b;
      ALU_AND:  alu_res = fwd_a & alu_b;
      ALU_LUI:  alu_res = alu_b << (WIDTH / 2);
      ALU_SLT:  alu_res = {{(WIDTH-1){1'b0}}, ($signed(fwd_a) < $signed(alu_b))};
      ALU_SLTU: alu_res = {{(WIDTH-1){1'b0}}, (fwd_a < alu_b)};
      ALU_XOR:  alu_res = fwd_a ^ alu_b;
      default:  alu_res = '0;
    endcase
  end

  e_mdu #(
    .WIDTH       (WIDTH),
    .MULT_CYCLES (MULT_CYCLES),
    .DIV_CYCLES  (DIV_CYCLES)
  ) u_mdu (
    .clk     (clk),
    .reset   (reset),
    .op_i    (ctrl_q.md_op),
    .a_i     (fwd_a),
    .b_i     (fwd_b),
    .start_o (md_start),
    .busy_o  (md_busy),
    .hi_o    (hi),
    .lo_o    (lo)
  );

  always_comb begin
    case (ctrl_q.md_read)
      MDREAD_HI: io.E_Result = hi;
      MDREAD_LO: io.E_Result = lo;
      default:   io.E_Result = alu_res;
    endcase
  end

  assign io.E_Instr    = instr_q;
  assign io.E_PC       = pc_q;
  assign io.E_PC8      = pc8_q;
  assign io.E_RD2      = fwd_b;
  assign io.E_RegAddr  = ctrl_q.reg_addr;
  assign io.E_RegWrite = ctrl_q.reg_write;
  assign io.E_Tnew     = tnew_dec(ctrl_q.tnew);
  assign io.E_MDBusy   = md_busy;
  assign io.E_MDStall  = (md_start | md_busy) & io.D_UsesMD;

endmodule

// File: tb/tb_e_stage_mdu.sv
// Directed scoreboard bench for the execute stage: E-stage results and MDU busy lengths checked by monitors.
module tb_e_stage_mdu;
  import e_stage_mdu_pkg::*;

  typedef struct {
    logic [31:0] instr, rd1, rd2, imm, m_dat, w_dat, exp_result, exp_rd2;
    logic [4:0]  rs, rt, rd, m_addr, w_addr;
    logic        we, alusrc, uses, m_we, w_we, force_stall;
    logic [2:0]  aluop, mdop, tnew, exp_tnew;
    logic [1:0]  mdread;
    int          busy_len, exp_stall;
  } tx_t;

  typedef struct {
    logic [31:0] instr, result, rd2;
    logic [4:0]  rd;
    logic        we;
    logic [2:0]  tnew;
  } exp_t;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  e_stage_mdu_if #(.WIDTH(32)) bus ();

  e_stage_mdu #(.WIDTH(32), .MULT_CYCLES(5), .DIV_CYCLES(10)) dut (
    .clk   (clk),
    .reset (reset),
    .io    (bus)
  );

  int   n_pass = 0;
  int   n_total = 0;
  exp_t exp_q[$];
  int   busy_q[$];
  exp_t mon_e;
  int   busy_run = 0;
  tx_t  t;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
  endtask

  function automatic tx_t t_nop();
    tx_t r;
    r = '{default: '0};
    r.exp_stall = -1;
    return r;
  endfunction

  function automatic tx_t t_alu(input logic [31:0] tag, input logic [2:0] op,
                                input logic [31:0] a, input logic [31:0] b, input logic [31:0] res);
    tx_t r;
    r = t_nop();
    r.instr = tag; r.aluop = op; r.rs = 5'd1; r.rt = 5'd2; r.rd = 5'd3; r.we = 1'b1;
    r.rd1 = a; r.rd2 = b; r.exp_result = res; r.exp_rd2 = b; r.tnew = 3'd1; r.exp_tnew = 3'd0;
    return r;
  endfunction

  function automatic tx_t t_imm(input logic [31:0] tag, input logic [2:0] op,
                                input logic [31:0] a, input logic [31:0] imm, input logic [31:0] res);
    tx_t r;
    r = t_alu(tag, op, a, 32'hDEAD, res);
    r.alusrc = 1'b1; r.imm = imm;
    return r;
  endfunction

  function automatic tx_t t_md(input logic [31:0] tag, input logic [2:0] op, input logic [31:0] a,
                               input logic [31:0] b, input logic [31:0] res, input int busy_len);
    tx_t r;
    r = t_alu(tag, ALU_ADD, a, b, res);
    r.mdop = op; r.uses = 1'b1; r.we = 1'b0; r.rd = 5'd0; r.busy_len = busy_len;
    return r;
  endfunction

  function automatic tx_t t_mf(input logic [31:0] tag, input logic [1:0] sel,
                               input logic [31:0] res, input int stall);
    tx_t r;
    r = t_alu(tag, ALU_ADD, 32'h0, 32'h0, res);
    r.rs = 5'd0; r.rt = 5'd0; r.mdread = sel; r.uses = 1'b1;
    r.tnew = 3'd2; r.exp_tnew = 3'd1; r.exp_stall = stall;
    return r;
  endfunction

  // Acts as the D stage: holds the instruction and bubbles E while E_MDStall is raised.
  task automatic drive(input tx_t x);
    exp_t e;
    int   n;
    if (x.instr != 0) begin
      e.instr = x.instr; e.result = x.exp_result; e.rd2 = x.exp_rd2;
      e.rd = x.rd; e.we = x.we; e.tnew = x.exp_tnew;
      exp_q.push_back(e);
    end
    if (x.busy_len != 0) busy_q.push_back(x.busy_len);
    bus.D_Instr = x.instr;  bus.D_PC = x.instr << 2; bus.D_PC8 = (x.instr << 2) + 32'd8;
    bus.D_RD1 = x.rd1;      bus.D_RD2 = x.rd2;       bus.D_Imm = x.imm;
    bus.D_rs = x.rs;        bus.D_rt = x.rt;         bus.D_RegAddr = x.rd;
    bus.D_RegWrite = x.we;  bus.D_ALUop = x.aluop;   bus.D_ALUSrc = x.alusrc;
    bus.D_MDop = x.mdop;    bus.D_MDRead = x.mdread; bus.D_UsesMD = x.uses;
    bus.D_Tnew = x.tnew;
    #1;
    if (x.force_stall) begin
      bus.Stall = 1'b1;
      @(posedge clk); #1;
      chk("bubble_we", 64'(bus.E_RegWrite), 64'd0);
      chk("bubble_instr", 64'(bus.E_Instr), 64'd0);
    end
    n = 0;
    while (bus.E_MDStall && n < 40) begin
      bus.Stall = 1'b1;
      @(posedge clk); #1;
      n++;
    end
    if (n >= 40) begin
      n_total++;
      $display("FAIL stall_bound: tag 0x%0h still stalled after %0d cycles, required release", x.instr, n);
    end
    if (x.exp_stall >= 0) chk("stall_cycles", 64'(n), 64'(x.exp_stall));
    bus.Stall = 1'b0;
    @(posedge clk); #1;
    bus.M_RegWrite = x.m_we; bus.M_RegAddr = x.m_addr; bus.M_RegData = x.m_dat;
    bus.W_RegWrite = x.w_we; bus.W_RegAddr = x.w_addr; bus.W_RegData = x.w_dat;
  endtask

  always @(negedge clk) begin
    if (!reset && bus.E_Instr != 32'd0) begin
      if (exp_q.size() == 0) begin
        n_total++;
        $display("FAIL unexpected_e: got instr 0x%0h, expected none", bus.E_Instr);
      end else begin
        mon_e = exp_q.pop_front();
        chk("tag", 64'(bus.E_Instr), 64'(mon_e.instr));
        chk("result", 64'(bus.E_Result), 64'(mon_e.result));
        chk("rd2", 64'(bus.E_RD2), 64'(mon_e.rd2));
        chk("ctrl", {55'd0, bus.E_RegAddr, bus.E_RegWrite, bus.E_Tnew},
                    {55'd0, mon_e.rd, mon_e.we, mon_e.tnew});
        chk("pc", {bus.E_PC, bus.E_PC8}, {mon_e.instr << 2, (mon_e.instr << 2) + 32'd8});
      end
    end
  end

  always @(negedge clk) begin
    if (bus.E_MDBusy === 1'b1) begin
      busy_run++;
    end else if (busy_run > 0) begin
      if (busy_q.size() == 0) begin
        n_total++;
        $display("FAIL unexpected_busy: got run of %0d, expected none", busy_run);
      end else begin
        chk("busy_len", 64'(busy_run), 64'(busy_q.pop_front()));
      end
      busy_run = 0;
    end
  end

  initial begin
    #50000;
    $display("FAIL watchdog: simulation time exhausted, required completion");
    $fatal(1);
  end

  initial begin
    reset = 1'b1;
    bus.Stall = 1'b0;
    bus.M_RegWrite = 1'b0; bus.M_RegAddr = 5'd0; bus.M_RegData = 32'd0;
    bus.W_RegWrite = 1'b0; bus.W_RegAddr = 5'd0; bus.W_RegData = 32'd0;
    t = t_nop();
    bus.D_Instr = 0; bus.D_PC = 0; bus.D_PC8 = 0; bus.D_RD1 = 0; bus.D_RD2 = 0; bus.D_Imm = 0;
    bus.D_rs = 0; bus.D_rt = 0; bus.D_RegAddr = 0; bus.D_RegWrite = 0; bus.D_ALUop = 0;
    bus.D_ALUSrc = 0; bus.D_MDop = 0; bus.D_MDRead = 0; bus.D_UsesMD = 0; bus.D_Tnew = 0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_instr", 64'(bus.E_Instr), 64'd0);
    chk("rst_result", 64'(bus.E_Result), 64'd0);
    chk("rst_we", 64'(bus.E_RegWrite), 64'd0);
    chk("rst_busy", 64'(bus.E_MDBusy), 64'd0);
    chk("rst_tnew", 64'(bus.E_Tnew), 64'd0);
    chk("rst_pc8", 64'(bus.E_PC8), 64'd0);
    reset = 1'b0;

    // Forwarding: M beats W, W alone, register 0 never forwarded, rt path.
    t = t_alu(32'h101, ALU_ADD, 32'h99, 32'h0, 32'h11); t.rs = 5'd8; t.rt = 5'd0;
    t.m_we = 1; t.m_addr = 5'd8; t.m_dat = 32'h11; t.w_we = 1; t.w_addr = 5'd8; t.w_dat = 32'h22;
    drive(t);
    t = t_alu(32'h102, ALU_ADD, 32'h99, 32'h5, 32'h27); t.rs = 5'd8; t.rt = 5'd9;
    t.w_we = 1; t.w_addr = 5'd8; t.w_dat = 32'h22; t.tnew = 3'd2; t.exp_tnew = 3'd1;
    drive(t);
    t = t_alu(32'h103, ALU_ADD, 32'h7, 32'h1, 32'h8); t.rs = 5'd0; t.rt = 5'd0;
    t.m_we = 1; t.m_addr = 5'd0; t.m_dat = 32'h55; t.w_we = 1; t.w_addr = 5'd0; t.w_dat = 32'h66;
    t.tnew = 3'd0; t.exp_tnew = 3'd0;
    drive(t);
    t = t_alu(32'h104, ALU_SUB, 32'h100, 32'h3, 32'hF0); t.rs = 5'd4; t.rt = 5'd9; t.exp_rd2 = 32'h10;
    t.m_we = 1; t.m_addr = 5'd9; t.m_dat = 32'h10; t.w_we = 1; t.w_addr = 5'd9; t.w_dat = 32'h20;
    drive(t);

    // ALU operations.
    drive(t_alu(32'h105, ALU_OR,   32'hF0,       32'h0F, 32'hFF));
    drive(t_imm(32'h106, ALU_AND,  32'hFF,       32'h3C, 32'h3C));
    drive(t_imm(32'h107, ALU_LUI,  32'h0,        32'h1234, 32'h1234_0000));
    drive(t_alu(32'h108, ALU_SLT,  32'hFFFF_FFFF, 32'h1, 32'h1));
    drive(t_alu(32'h109, ALU_SLTU, 32'hFFFF_FFFF, 32'h1, 32'h0));
    drive(t_alu(32'h10A, ALU_XOR,  32'hFF00,     32'h0FF0, 32'hF0F0));
    drive(t_alu(32'h10B, ALU_SUB,  32'h0,        32'h1, 32'hFFFF_FFFF));

    // Multiply / divide with dependent HI/LO reads.
    drive(t_md(32'h201, MD_MULT,  32'hFFFF_FFFB, 32'h3, 32'hFFFF_FFFE, 5));
    drive(t_mf(32'h202, MDREAD_LO, 32'hFFFF_FFF1, 6));
    drive(t_mf(32'h203, MDREAD_HI, 32'hFFFF_FFFF, 0));
    drive(t_md(32'h204, MD_MULTU, 32'hFFFF_FFFF, 32'h2, 32'h1, 5));
    drive(t_mf(32'h205, MDREAD_HI, 32'h1, 6));
    drive(t_mf(32'h206, MDREAD_LO, 32'hFFFF_FFFE, 0));
    drive(t_md(32'h207, MD_DIV,   32'h7, 32'hFFFF_FFFE, 32'h5, 10));
    drive(t_mf(32'h208, MDREAD_LO, 32'hFFFF_FFFD, 11));
    drive(t_mf(32'h209, MDREAD_HI, 32'h1, 0));
    drive(t_md(32'h20A, MD_DIVU,  32'h7, 32'h0, 32'h7, 10));
    drive(t_mf(32'h20B, MDREAD_HI, 32'h1, 11));
    drive(t_mf(32'h20C, MDREAD_LO, 32'hFFFF_FFFD, 0));
    drive(t_md(32'h20D, MD_MTHI,  32'hABCD, 32'h0, 32'hABCD, 0));
    drive(t_mf(32'h20E, MDREAD_HI, 32'hABCD, 0));
    drive(t_md(32'h20F, MD_MTLO,  32'h1357, 32'h0, 32'h1357, 0));
    drive(t_mf(32'h210, MDREAD_LO, 32'h1357, 0));

    // Reset during the third busy cycle of a divide.
    drive(t_md(32'h211, MD_DIV, 32'h9, 32'h2, 32'hB, 3));
    repeat (3) drive(t_nop());
    reset = 1'b1;
    @(posedge clk); #1;
    chk("midrst_busy", 64'(bus.E_MDBusy), 64'd0);
    chk("midrst_instr", 64'(bus.E_Instr), 64'd0);
    chk("midrst_result", 64'(bus.E_Result), 64'd0);
    chk("midrst_we", 64'(bus.E_RegWrite), 64'd0);
    reset = 1'b0;
    drive(t_mf(32'h212, MDREAD_HI, 32'h0, 0));
    drive(t_mf(32'h213, MDREAD_LO, 32'h0, 0));

    // Stall pulse: bubble first, then the held sltu.
    t = t_alu(32'h301, ALU_SLTU, 32'h1, 32'hFFFF_FFFF, 32'h1); t.force_stall = 1'b1;
    drive(t);

    repeat (3) drive(t_nop());
    chk("exp_q_drained", 64'(exp_q.size()), 64'd0);
    chk("busy_q_drained", 64'(busy_q.size()), 64'd0);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
